// File: rtl/hazard_ctrl.sv
// Load-use hazard detection and branch/jump redirect sequencing for a 16-bit pipeline.
// Tracks the instruction in EX and drives the stall, redirect and flush controls.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_we_i,
  input  logic        id_load_i,
  input  logic        id_jmp_i,
  input  logic [15:0] id_jmp_tgt_i,
  input  logic        ex_br_taken_i,
  input  logic [15:0] ex_br_tgt_i,
  output logic        haz_o,
  output logic [15:0] cnt_jmp_o,
  output logic        flush_o,
  output logic [15:0] stall_cnt_o,
  output logic        bad_tgt_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_ex_rd;
  logic        r_ex_we;
  logic        r_ex_load;
  logic [15:0] r_tgt;
  logic [15:0] r_cnt_jmp;
  logic        r_flush;
  logic [15:0] r_stall_cnt;
  logic        r_bad_tgt;

  logic        w_idle;
  logic        w_rs_hit;
  logic        w_rt_hit;
  logic        w_haz;
  logic        w_take_br;
  logic        w_take_jmp;
  logic [15:0] w_tgt;
  logic [15:0] w_stall_nxt;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_rs_hit    = id_use_rs_i && (id_rs_i == r_ex_rd);
  assign w_rt_hit    = id_use_rt_i && (id_rt_i == r_ex_rd);
  assign w_haz       = w_idle && id_valid_i && r_ex_load && r_ex_we &&
                       (r_ex_rd != 5'd0) && (w_rs_hit || w_rt_hit);
  // A taken branch in EX overrides a younger jump sitting in ID.
  assign w_take_br   = ex_br_taken_i;
  assign w_take_jmp  = id_valid_i && id_jmp_i && !w_haz;
  assign w_tgt       = w_take_br ? ex_br_tgt_i : id_jmp_tgt_i;
  assign w_stall_nxt = (w_haz && (r_stall_cnt != 16'hFFFF)) ? (r_stall_cnt + 16'd1) : r_stall_cnt;

  assign haz_o       = w_haz;
  assign cnt_jmp_o   = r_cnt_jmp;
  assign flush_o     = r_flush;
  assign stall_cnt_o = r_stall_cnt;
  assign bad_tgt_o   = r_bad_tgt;

  // EX shadow: accept the ID instruction only when nothing stalls or redirects.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_ex_rd   <= 5'd0;
      r_ex_we   <= 1'b0;
      r_ex_load <= 1'b0;
    end else if (w_idle && !w_haz) begin
      r_ex_rd   <= id_valid_i ? id_rd_i : 5'd0;
      r_ex_we   <= id_valid_i && id_we_i;
      r_ex_load <= id_valid_i && id_load_i;
    end else begin
      r_ex_rd   <= 5'd0;
      r_ex_we   <= 1'b0;
      r_ex_load <= 1'b0;
    end
  end

  // Stall cycle counter, saturating.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
    end
  end

  // Redirect sequencer with registered redirect/flush outputs.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_tgt     <= 16'd0;
      r_cnt_jmp <= 16'd0;
      r_flush   <= 1'b0;
      r_bad_tgt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_br || w_take_jmp) begin
            r_state   <= ST_REDIRECT;
            r_tgt     <= w_tgt;
            r_cnt_jmp <= w_tgt;
            r_flush   <= 1'b1;
            r_bad_tgt <= r_bad_tgt || (w_tgt == 16'd0);
          end else begin
            r_cnt_jmp <= 16'd0;
            r_flush   <= 1'b0;
          end
        end
        ST_REDIRECT: begin
          r_state   <= ST_FLUSH;
          r_cnt_jmp <= 16'd0;
          r_flush   <= 1'b1;
        end
        ST_FLUSH: begin
          r_state   <= ST_IDLE;
          r_cnt_jmp <= 16'd0;
          r_flush   <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt_jmp <= 16'd0;
          r_flush   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver feeds a behavioural model and queues
// expected outputs; an independent monitor compares them against the DUT each cycle.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst   = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs_i = 5'd0;
  logic [4:0]  id_rt_i = 5'd0;
  logic        id_use_rs_i = 1'b0;
  logic        id_use_rt_i = 1'b0;
  logic [4:0]  id_rd_i = 5'd0;
  logic        id_we_i = 1'b0;
  logic        id_load_i = 1'b0;
  logic        id_jmp_i = 1'b0;
  logic [15:0] id_jmp_tgt_i = 16'd0;
  logic        ex_br_taken_i = 1'b0;
  logic [15:0] ex_br_tgt_i = 16'd0;
  logic        haz_o;
  logic [15:0] cnt_jmp_o;
  logic        flush_o;
  logic [15:0] stall_cnt_o;
  logic        bad_tgt_o;

  hazard_ctrl dut (
    .clk_i(clk_i), .rst(rst), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i), .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .id_load_i(id_load_i), .id_jmp_i(id_jmp_i), .id_jmp_tgt_i(id_jmp_tgt_i),
    .ex_br_taken_i(ex_br_taken_i), .ex_br_tgt_i(ex_br_tgt_i), .haz_o(haz_o),
    .cnt_jmp_o(cnt_jmp_o), .flush_o(flush_o), .stall_cnt_o(stall_cnt_o), .bad_tgt_o(bad_tgt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        haz;
    logic [15:0] cnt;
    logic        flush;
    logic [15:0] stall;
    logic        bad;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: the instruction sitting in EX, and how many redirect cycles remain.
  logic [4:0]  m_rd;
  logic        m_we;
  logic        m_ld;
  int          m_phase;
  logic [15:0] m_tgt;
  logic [15:0] m_stall;
  logic        m_bad;

  task automatic model_reset();
    m_rd = 5'd0; m_we = 1'b0; m_ld = 1'b0;
    m_phase = 0; m_tgt = 16'd0; m_stall = 16'd0; m_bad = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      n_err++;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic we, input logic ld, input logic jmp, input logic [15:0] jt,
                       input logic br, input logic [15:0] bt);
    exp_t e;
    logic idle;
    logic hz;
    @(negedge clk_i);
    id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_use_rs_i = urs; id_use_rt_i = urt;
    id_rd_i = rd; id_we_i = we; id_load_i = ld; id_jmp_i = jmp; id_jmp_tgt_i = jt;
    ex_br_taken_i = br; ex_br_tgt_i = bt;
    idle = (m_phase == 0);
    hz = idle && v && m_ld && m_we && (m_rd != 5'd0) &&
         ((urs && rs == m_rd) || (urt && rt == m_rd));
    if (hz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (!idle) begin
      m_phase = m_phase - 1;
    end else if (br || (v && jmp && !hz)) begin
      m_tgt = br ? bt : jt;
      m_phase = 2;
      if (m_tgt == 16'd0) m_bad = 1'b1;
    end
    if (idle && !hz && v) begin
      m_rd = rd; m_we = we; m_ld = ld;
    end else begin
      m_rd = 5'd0; m_we = 1'b0; m_ld = 1'b0;
    end
    e.haz = hz;
    e.cnt = (m_phase == 2) ? m_tgt : 16'd0;
    e.flush = (m_phase != 0);
    e.stall = m_stall;
    e.bad = m_bad;
    q.push_back(e);
  endtask

  task automatic idle_cyc();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic rand_cyc();
    logic [15:0] jt;
    logic [15:0] bt;
    jt = ($urandom % 16 == 0) ? 16'd0 : 16'($urandom);
    bt = ($urandom % 16 == 0) ? 16'd0 : 16'($urandom);
    drive(($urandom % 8) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), ($urandom % 4) != 0,
          ($urandom % 3) == 0, ($urandom % 8) == 0, jt, ($urandom % 10) == 0, bt);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk_i);
    #2;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      n_err++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    n_vec++;
    chk({tag, "_haz"}, {15'd0, haz_o}, 16'd0);
    chk({tag, "_cnt"}, cnt_jmp_o, 16'd0);
    chk({tag, "_flush"}, {15'd0, flush_o}, 16'd0);
    chk({tag, "_stall"}, stall_cnt_o, 16'd0);
    chk({tag, "_bad"}, {15'd0, bad_tgt_o}, 16'd0);
  endtask

  // Monitor: haz_o is sampled before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    logic h;
    forever begin
      @(negedge clk_i);
      #2;
      if (q.size() > 0) begin
        h = haz_o;
        @(posedge clk_i);
        #1;
        e = q.pop_front();
        n_vec++;
        chk("haz", {15'd0, h}, {15'd0, e.haz});
        chk("cnt_jmp", cnt_jmp_o, e.cnt);
        chk("flush", {15'd0, flush_o}, {15'd0, e.flush});
        chk("stall_cnt", stall_cnt_o, e.stall);
        chk("bad_tgt", {15'd0, bad_tgt_o}, {15'd0, e.bad});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst = 1'b1;

    // load-use on r5, then r0 and unused-operand cases
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd9, 5'd9, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
    idle_cyc();

    // branch, branch-vs-jump priority, branch ignored in FLUSH
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'h0040);
    idle_cyc(); idle_cyc(); idle_cyc();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0100);
    idle_cyc();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0500, 1'b1, 16'h0300);
    idle_cyc(); idle_cyc();
    // jump blocked while a load-use stall is active
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0777, 1'b0, 16'd0);
    idle_cyc(); idle_cyc(); idle_cyc();

    // reset asserted while REDIRECT is showing
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 16'h1234);
    @(posedge clk_i);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_redirect");
    model_reset();
    id_valid_i = 1'b0; ex_br_taken_i = 1'b0; id_jmp_i = 1'b0;
    @(negedge clk_i);
    rst = 1'b1;
    idle_cyc(); idle_cyc(); idle_cyc();

    // zero jump target sets a sticky error
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0);
    repeat (4) idle_cyc();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0044, 1'b0, 16'd0);
    repeat (3) idle_cyc();

    // preload the stall counter near its ceiling, then keep stalling
    @(posedge clk_i);
    #2;
    force dut.r_stall_cnt = 16'hFFFD;
    @(posedge clk_i);
    #1;
    release dut.r_stall_cnt;
    m_stall = 16'hFFFD;
    repeat (10) drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    idle_cyc();
    drain();

    repeat (1500) rand_cyc();
    drain();
    rst = 1'b0;
    #1;
    chk_all_zero("rst_random");
    model_reset();
    id_valid_i = 1'b0; ex_br_taken_i = 1'b0; id_jmp_i = 1'b0;
    @(negedge clk_i);
    rst = 1'b1;
    repeat (500) rand_cyc();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have no parameters; widths are fixed: PC/target 16 bits, register index 5 bits.
REQ-002 SHALL provide: clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide: id_valid_i  in  1  ID-stage instruction valid.
REQ-005 SHALL provide: id_rs_i, id_rt_i  in  5 each  ID source register indices.
REQ-006 SHALL provide: id_use_rs_i, id_use_rt_i  in  1 each  ID instruction reads rs/rt.
REQ-007 SHALL provide: id_rd_i  in  5  ID destination index; id_we_i  in  1  ID writes rd; id_load_i  in  1  ID is a load.
REQ-008 SHALL provide: id_jmp_i  in  1  ID is an unconditional jump; id_jmp_tgt_i  in  16  jump target.
REQ-009 SHALL provide: ex_br_taken_i  in  1  EX branch resolved taken; ex_br_tgt_i  in  16  branch target.
REQ-010 SHALL provide: haz_o  out  1  stall PC and IF/ID; matches PC-unit haz_i.
REQ-011 SHALL provide: cnt_jmp_o  out  16  redirect target, 0 = no redirect; matches PC-unit cnt_jmp_i.
REQ-012 SHALL provide: flush_o  out  1  kill IF/ID contents; stall_cnt_o  out  16  stall cycle count; bad_tgt_o  out  1  sticky zero-target error.

Function
REQ-013 SHALL keep shadow EX-stage state: ex_rd (5b), ex_we, ex_load.
REQ-014 Each edge with state IDLE and haz_o=0: SHALL load shadow from ID inputs, gated by id_valid_i.
REQ-015 Each edge otherwise (stall, REDIRECT, FLUSH): SHALL load a bubble (ex_we=0, ex_load=0, ex_rd=0).
REQ-016 SHALL drive haz_o combinationally: 1 iff state IDLE, id_valid_i, ex_load, ex_we, ex_rd!=0, and (id_use_rs_i & id_rs_i==ex_rd or id_use_rt_i & id_rt_i==ex_rd).
REQ-017 Load-use stall SHALL last exactly 1 cycle; the bubble clears the condition.
REQ-018 SHALL never flag a hazard on register 0.
REQ-019 SHALL implement FSM states IDLE, REDIRECT, FLUSH.
REQ-020 IDLE: ex_br_taken_i=1 at an edge SHALL latch ex_br_tgt_i and go to REDIRECT.
REQ-021 IDLE: else, id_valid_i & id_jmp_i & haz_o=0 at an edge SHALL latch id_jmp_tgt_i and go to REDIRECT.
REQ-022 Branch SHALL have priority over jump in the same cycle; the jump is dropped (wrong path).
REQ-023 REDIRECT, one cycle: cnt_jmp_o = latched target, flush_o=1; next state FLUSH.
REQ-024 FLUSH, one cycle: cnt_jmp_o=0, flush_o=1; next state IDLE.
REQ-025 In IDLE, cnt_jmp_o SHALL be 0 and flush_o 0.
REQ-026 ex_br_taken_i and id_jmp_i SHALL be ignored in REDIRECT and FLUSH (wrong-path instructions).
REQ-027 A latched target of 0 SHALL still run REDIRECT/FLUSH with cnt_jmp_o=0, and SHALL set bad_tgt_o=1 until reset.
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where haz_o=1 and saturate at 16'hFFFF (no wrap).
REQ-029 All outputs other than haz_o SHALL be registered.

Reset
REQ-030 rst=0 SHALL asynchronously force: state IDLE, shadow bubble, latched target 0, cnt_jmp_o=0, flush_o=0, stall_cnt_o=0, bad_tgt_o=0; haz_o is therefore 0.
REQ-031 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort immediately with no redirect after release.
REQ-032 First state update SHALL occur on the first rising clk_i with rst=1.

Verification
REQ-033 Load-use: load rd=5 accepted; next cycle ID reads rs=5 -> haz_o=1 for 1 cycle, stall_cnt_o=1, then haz_o=0.
REQ-034 Register 0 and no-use: load rd=0 then rs=0 -> haz_o=0. Load rd=7 then id_use_rt_i=0, rt=7 -> haz_o=0.
REQ-035 Branch: ex_br_taken_i=1, tgt=16'h0040 -> next cycle cnt_jmp_o=0x0040, flush_o=1; following cycle cnt_jmp_o=0, flush_o=1; then IDLE.
REQ-036 Priority and ignore: branch tgt 0x0100 and jump tgt 0x0200 on same edge -> cnt_jmp_o=0x0100. Second branch during FLUSH -> ignored.
REQ-037 Zero target and reset: jump tgt 0 -> bad_tgt_o=1 and sticky. rst=0 during REDIRECT -> all outputs 0 immediately.
REQ-038 Saturation: force 65536 hazard cycles -> stall_cnt_o stays 0xFFFF.
